mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) round-robin arbiter in front of a single-ported memory.
// One transaction in flight: accept -> ISSUE -> DATA [-> HOLD] -> IDLE.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [63:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [63:0] lsu_rdata,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, HOLD} state_t;

  state_t      state, state_nxt;
  logic        last_lsu, owner_lsu, wen_q;
  logic [63:0] addr_q, wdata_q, buf_q;
  logic [7:0]  wmask_q;
  logic        ifu_grant, lsu_grant, owner_ready, resp_active;
  logic [63:0] resp_data;

  always_comb begin
    state_nxt   = state;
    ifu_grant   = 1'b0;
    lsu_grant   = 1'b0;
    resp_active = 1'b0;
    resp_data   = '0;
    owner_ready = owner_lsu ? lsu_resp_ready : ifu_resp_ready;
    case (state)
      IDLE: begin
        // no grant while reset is held, so nothing is accepted during reset
        if (!reset) begin
          ifu_grant = ifu_req_valid && (!lsu_req_valid || last_lsu);
          lsu_grant = lsu_req_valid && !ifu_grant;
          if (ifu_grant || lsu_grant) state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = DATA;
      DATA: begin
        resp_active = 1'b1;
        resp_data   = wen_q ? 64'd0 : mem_rdata;
        state_nxt   = owner_ready ? IDLE : HOLD;
      end
      HOLD: begin
        resp_active = 1'b1;
        resp_data   = buf_q;
        if (owner_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_lsu  <= 1'b1;
      owner_lsu <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      buf_q     <= '0;
    end else begin
      state <= state_nxt;
      if (ifu_grant || lsu_grant) begin
        owner_lsu <= lsu_grant;
        last_lsu  <= lsu_grant;
        addr_q    <= lsu_grant ? lsu_addr : ifu_addr;
        wen_q     <= lsu_grant && lsu_wen;
        wdata_q   <= lsu_grant ? lsu_wdata : 64'd0;
        wmask_q   <= lsu_grant ? lsu_wmask : 8'd0;
      end
      // memory data is only valid for one cycle; keep it for a stalled owner
      if (state == DATA && !owner_ready) buf_q <= resp_data;
    end
  end

  assign ifu_req_ready  = ifu_grant;
  assign lsu_req_ready  = lsu_grant;
  assign ifu_resp_valid = resp_active && !owner_lsu;
  assign lsu_resp_valid = resp_active && owner_lsu;
  assign ifu_rdata      = ifu_resp_valid ? resp_data : 64'd0;
  assign lsu_rdata      = lsu_resp_valid ? resp_data : 64'd0;

  assign mem_valid = (state == ISSUE);
  assign mem_wen   = wen_q;
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule
